// File: rtl/dp_pkg.sv
// Shared state encoding, unit-latency derivation and lane-slice helper for dp_feeder.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } dp_state_t;

    // Dot-product unit latency from operand-register load to dp_out.
    function automatic int dp_lat(input int n_mul);
        return $clog2(n_mul) + 2;
    endfunction

    // Low bit of lane `lane` in a packed operand bus of `dw`-bit lanes.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/dp_feeder_tag_pipe.sv
// Shift register of {valid,last} tags: a tag loaded on edge E is presented after edge E+DEPTH-1.
// No backpressure; all stages clear on synchronous active-low reset.
module dp_feeder_tag_pipe #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
            last_sr  <= {last_sr[DEPTH-2:0], in_last};
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/dp_feeder.sv
// Drives operand chunks into one dot-product unit and accumulates its partial sums into one result per job;
// result 3+DP_LAT edges after the last chunk, op_ready low in DRAIN/DONE, DONE held until res_ready. DP_FEEDER_SAT_EN: saturating accumulation.
module dp_feeder
    import dp_pkg::*;
#(
    parameter int N_MUL      = 4,
    parameter int DW_MUL     = 32,
    parameter int DW_ADD     = 32,
    parameter int MAX_CHUNKS = 16,
    localparam int CW        = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CW-1:0]           cfg_chunks,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DW_MUL*N_MUL-1:0] op_a,
    input  logic [DW_MUL*N_MUL-1:0] op_b,
    output logic                    dp_enable,
    output logic [1:0]              dp_in_valid,
    output logic [DW_MUL*N_MUL-1:0] dp_in_a,
    output logic [DW_MUL*N_MUL-1:0] dp_in_b,
    input  logic [DW_ADD-1:0]       dp_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DW_ADD-1:0]       res_data
);

    localparam int DP_LAT    = dp_lat(N_MUL);
    localparam int TAG_DEPTH = DP_LAT + 3;
    localparam int OPW       = DW_MUL * N_MUL;

    dp_state_t         state, state_nxt;
    logic [CW-1:0]     remaining;
    logic [CW-1:0]     job_chunks;
    logic              can_accept;
    logic              accept;
    logic              tag_in_last;
    logic              tag_valid;
    logic              tag_last;
    logic [OPW-1:0]    hold_a, hold_b;
    logic [DW_ADD-1:0] acc, acc_sum;

    assign can_accept  = reset_n && (state == IDLE || state == FEED);
    assign op_ready    = can_accept;
    assign accept      = op_valid && can_accept;
    assign dp_enable   = reset_n;
    assign res_valid   = reset_n && (state == DONE);
    assign job_chunks  = (cfg_chunks == '0) ? CW'(1) : cfg_chunks;
    // In IDLE the job length comes from cfg; afterwards from the running count.
    assign tag_in_last = (state == IDLE) ? (job_chunks == CW'(1)) : (remaining == CW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = tag_in_last ? DRAIN : FEED;
            FEED:    if (accept && tag_in_last) state_nxt = DRAIN;
            DRAIN:   if (tag_valid && tag_last) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DP_FEEDER_SAT_EN
    logic [DW_ADD:0] wide_sum;

    always_comb begin
        wide_sum = {acc[DW_ADD-1], acc} + {dp_out[DW_ADD-1], dp_out};
        acc_sum  = wide_sum[DW_ADD-1:0];
        // Sign bits disagree only on overflow; clamp toward the true sign.
        if (wide_sum[DW_ADD] != wide_sum[DW_ADD-1])
            acc_sum = wide_sum[DW_ADD] ? {1'b1, {(DW_ADD-1){1'b0}}} : {1'b0, {(DW_ADD-1){1'b1}}};
    end
`else
    assign acc_sum = acc + dp_out;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            remaining   <= '0;
            acc         <= '0;
            res_data    <= '0;
            dp_in_valid <= 2'b00;
            hold_a      <= '0;
            hold_b      <= '0;
            dp_in_a     <= '0;
            dp_in_b     <= '0;
        end else begin
            dp_in_valid <= accept ? 2'b11 : 2'b00;
            if (accept) begin
                hold_a    <= op_a;
                hold_b    <= op_b;
                remaining <= (state == IDLE) ? job_chunks - CW'(1) : remaining - CW'(1);
            end
            // Data follows its valid strobe by one cycle.
            if (dp_in_valid[1]) dp_in_a <= hold_a;
            if (dp_in_valid[0]) dp_in_b <= hold_b;
            if (accept && state == IDLE) acc <= '0;
            else if (tag_valid)          acc <= acc_sum;
            if (tag_valid && tag_last) res_data <= acc_sum;
        end
    end

    dp_feeder_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_last   (accept && tag_in_last),
        .out_valid (tag_valid),
        .out_last  (tag_last)
    );

endmodule

// File: tb/tb_dp_feeder.sv
// Directed and random jobs against dp_feeder with a behavioural dot-product unit and a per-job result model.
module tb_dp_feeder;
    import dp_pkg::*;

    localparam int N    = 4;
    localparam int DWM  = 32;
    localparam int DWA  = 32;
    localparam int MAXC = 16;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int OPW  = N * DWM;
    localparam int LAT  = dp_lat(N);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [CW-1:0]  cfg_chunks = '0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [OPW-1:0] op_a = '0;
    logic [OPW-1:0] op_b = '0;
    logic           dp_enable;
    logic [1:0]     dp_in_valid;
    logic [OPW-1:0] dp_in_a, dp_in_b;
    logic [DWA-1:0] dp_out;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [DWA-1:0] res_data;

    int             nchk = 0;
    int             nerr = 0;
    longint         t_acc, t_first;
    logic [OPW-1:0] ja[MAXC];
    logic [OPW-1:0] jb[MAXC];

    always #5 clk = ~clk;

    dp_feeder #(.N_MUL(N), .DW_MUL(DWM), .DW_ADD(DWA), .MAX_CHUNKS(MAXC)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_chunks(cfg_chunks),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .dp_enable(dp_enable), .dp_in_valid(dp_in_valid), .dp_in_a(dp_in_a), .dp_in_b(dp_in_b),
        .dp_out(dp_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Exact signed dot product of one chunk, reduced to DWA bits.
    function automatic logic [DWA-1:0] partial(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(a[lane_lo(i, DWM) +: DWM])) * longint'($signed(b[lane_lo(i, DWM) +: DWM]));
        return s[DWA-1:0];
    endfunction

    // Behavioural unit: valid strobe one cycle ahead of data, then LAT cycles to dp_out.
    logic [1:0]     u_vq = 2'b00;
    logic [OPW-1:0] u_ra = '0, u_rb = '0;
    logic [DWA-1:0] u_s[LAT];

    always @(posedge clk) begin
        if (!dp_enable) begin
            u_vq <= 2'b00;
            for (int k = 0; k < LAT; k++) u_s[k] <= '0;
        end else begin
            u_vq <= dp_in_valid;
            if (u_vq[1]) u_ra <= dp_in_a;
            if (u_vq[0]) u_rb <= dp_in_b;
            u_s[0] <= partial(u_ra, u_rb);
            for (int k = 1; k < LAT; k++) u_s[k] <= u_s[k-1];
        end
    end
    assign dp_out = u_s[LAT-1];

    function automatic logic [DWA-1:0] step(input logic [DWA-1:0] acc, input logic [DWA-1:0] p);
        longint smax = (longint'(1) <<< (DWA - 1)) - 1;
        longint s    = longint'($signed(acc)) + longint'($signed(p));
`ifdef DP_FEEDER_SAT_EN
        if (s > smax)      s = smax;
        if (s < -smax - 1) s = -smax - 1;
`endif
        return s[DWA-1:0];
    endfunction

    function automatic logic [DWA-1:0] ref_job(input int n);
        logic [DWA-1:0] acc = '0;
        for (int i = 0; i < n; i++) acc = step(acc, partial(ja[i], jb[i]));
        return acc;
    endfunction

    function automatic logic [OPW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        logic [OPW-1:0] v = '0;
        v[lane_lo(0, DWM) +: DWM] = DWM'(l0);
        v[lane_lo(1, DWM) +: DWM] = DWM'(l1);
        v[lane_lo(2, DWM) +: DWM] = DWM'(l2);
        v[lane_lo(3, DWM) +: DWM] = DWM'(l3);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; t_acc records the accepting edge.
    task automatic drive_chunk(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int cfg);
        int n = 0;
        op_a = a; op_b = b; cfg_chunks = CW'(cfg); op_valid = 1'b1;
        while (!op_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", OPW'(op_ready), OPW'(1));
        @(posedge clk);
        t_acc = longint'($time);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [DWA-1:0] d, output int lat);
        int n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        chk("res_timeout", OPW'(res_valid), OPW'(1));
        d   = res_data;
        lat = int'((longint'($time) - t_acc - 5) / 10);
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("res_released", OPW'(res_valid), OPW'(0));
    endtask

    task automatic no_result(input string tag, input int cycles);
        bit seen = 1'b0;
        repeat (cycles) begin @(negedge clk); if (res_valid) seen = 1'b1; end
        chk(tag, OPW'(seen), OPW'(0));
    endtask

    task automatic job(input string tag, input int n, input int cfg, input int gap,
                       input logic [DWA-1:0] exp, output int latf);
        logic [DWA-1:0] d;
        int lat;
        for (int i = 0; i < n; i++) begin
            drive_chunk(ja[i], jb[i], (i == 0) ? cfg : int'($urandom));
            if (i == 0) t_first = t_acc;
            if (i < n - 1) repeat (gap) @(negedge clk);
        end
        wait_result(d, lat);
        chk({tag, "_data"}, OPW'(d), OPW'(exp));
        chk({tag, "_lat"}, OPW'(lat), OPW'(LAT + 3));
        latf = int'((t_acc - t_first) / 10) + lat;
        finish_result();
    endtask

    initial begin
        logic [DWA-1:0] d;
        int  lat, latf, n, gap;
        bit  stable;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_ready", OPW'(op_ready), OPW'(0));
        chk("rst_res_valid", OPW'(res_valid), OPW'(0));
        chk("rst_res_data", OPW'(res_data), OPW'(0));
        chk("rst_dp_in_valid", OPW'(dp_in_valid), OPW'(0));
        chk("rst_dp_enable", OPW'(dp_enable), OPW'(0));
        chk("rst_dp_in_a", dp_in_a, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_op_ready", OPW'(op_ready), OPW'(1));
        chk("run_dp_enable", OPW'(dp_enable), OPW'(1));

        // Single chunk with strobe/data timing
        ja[0] = pack(1, 2, 3, 4);
        jb[0] = pack(5, 6, 7, 8);
        drive_chunk(ja[0], jb[0], 1);
        chk("t1_in_valid", OPW'(dp_in_valid), OPW'(3));
        @(negedge clk);
        chk("t1_in_a", dp_in_a, ja[0]);
        chk("t1_in_b", dp_in_b, jb[0]);
        chk("t1_in_valid_off", OPW'(dp_in_valid), OPW'(0));
        chk("t1_drain_op_ready", OPW'(op_ready), OPW'(0));
        wait_result(d, lat);
        chk("t1_data", OPW'(d), OPW'(70));
        chk("t1_lat", OPW'(lat), OPW'(7));
        finish_result();

        // Two chunks back-to-back, then with a 3-cycle gap
        ja[1] = pack(-1, -1, -1, -1);
        jb[1] = pack(2, 2, 2, 2);
        job("t2", 2, 2, 0, 32'd62, latf);
        chk("t2_lat_first", OPW'(latf), OPW'(8));
        no_result("t2_single", 15);
        job("t3", 2, 2, 3, 32'd62, latf);
        chk("t3_lat_first", OPW'(latf), OPW'(11));

        // Result held while res_ready is low
        res_ready = 1'b0;
        drive_chunk(ja[0], jb[0], 1);
        wait_result(d, lat);
        chk("t4_data", OPW'(d), OPW'(70));
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (res_data !== d || op_ready !== 1'b0 || res_valid !== 1'b1) stable = 1'b0;
        end
        chk("t4_hold", OPW'(stable), OPW'(1));
        finish_result();
        for (int i = 0; i < 3; i++) begin
            ja[i] = {$urandom, $urandom, $urandom, $urandom};
            jb[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        job("t4_job1", 3, 3, 0, ref_job(3), latf);
        for (int i = 0; i < 2; i++) begin
            ja[i] = {$urandom, $urandom, $urandom, $urandom};
            jb[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        job("t4_job2", 2, 2, 0, ref_job(2), latf);

        // Reset during DRAIN abandons the job
        ja[0] = pack(1, 2, 3, 4);
        jb[0] = pack(5, 6, 7, 8);
        drive_chunk(ja[0], jb[0], 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        no_result("t5_abandoned", 15);
        job("t5_after", 1, 1, 0, 32'd70, latf);

        // cfg_chunks of zero behaves as one chunk
        job("t6_cfg0", 1, 0, 0, 32'd70, latf);

        // Overflow in the accumulator
        ja[0] = pack(32'h7FFF_FFFF, 0, 0, 0);
        jb[0] = pack(1, 0, 0, 0);
        ja[1] = ja[0];
        jb[1] = jb[0];
`ifdef DP_FEEDER_SAT_EN
        job("t7_pos", 2, 2, 0, 32'h7FFF_FFFF, latf);
`else
        job("t7_pos", 2, 2, 0, 32'hFFFF_FFFE, latf);
`endif
        ja[0] = pack(32'h8000_0000, 0, 0, 0);
        ja[1] = ja[0];
`ifdef DP_FEEDER_SAT_EN
        job("t7_neg", 2, 2, 0, 32'h8000_0000, latf);
`else
        job("t7_neg", 2, 2, 0, 32'h0000_0000, latf);
`endif

        // Random jobs, lengths and gaps
        for (int j = 0; j < 20; j++) begin
            n   = int'($urandom_range(1, MAXC));
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                ja[i] = {$urandom, $urandom, $urandom, $urandom};
                jb[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            job("rnd", n, n, gap, ref_job(n), latf);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
